random_bag_generator: RTL and testbench
=======================================

# random_bag_generator

Parametrised successor to `random_generator`. A Galois LFSR feeds a rejection sampler that produces item indices in `[0, items_p)` over a valid/ready output. There are two modes: uniform draws with replacement, and "bag" draws, where each full bag of `items_p` items is a permutation before the bag refills. It sits between the game controller and the next-piece queue, with `items_p = 7` for tetromino selection.

## Interface
Parameters:
- `width_p`, 16: LFSR width in bits.
- `mask_p`, `16'hB400`: Galois tap mask. Must be maximal-length for `width_p`.
- `items_p`, 7: number of distinct items. Requires `2 <= items_p <= 2**width_p`. Item width `iw = $clog2(items_p)`.

Ports:
- `clk_i`, in, 1: clock. One clock domain only.
- `reset_i`, in, 1: synchronous, active-high reset.
- `seed_i`, in, `width_p`: seed value, sampled when `seed_v_i = 1`.
- `seed_v_i`, in, 1: load seed, clear the bag, and start drawing.
- `mode_i`, in, 1: 0 = uniform, 1 = bag. Sampled every DRAW cycle.
- `v_o`, out, 1: `item_o` is valid.
- `item_o`, out, `iw`: drawn item index.
- `ready_i`, in, 1: consumer accepts `item_o`. A handshake occurs when `v_o & ready_i`.

## Operation
- LFSR step: `lfsr_n = (lfsr >> 1) ^ (lfsr[0] ? mask_p : 0)`.
  - Steps every cycle while state != IDLE, except in the seed-load cycle.
  - Holds in IDLE.
- Seed load: `lfsr <= (seed_i == 0) ? 1 : seed_i`. The zero seed is remapped to avoid lock-up.
- Candidate `c = lfsr[iw-1:0]`, taken from the current register value.
- `used` register: `items_p` bits, one per item already drawn in the current bag.
- State IDLE (after reset):
  - `v_o = 0`.
  - `seed_v_i` moves to DRAW. No other exit.
- State DRAW:
  - Accept `c` when `c < items_p` and (`mode_i == 0` or `!used[c]`). Otherwise reject, stay in DRAW, and retry next cycle with the stepped LFSR.
  - On accept:
    - `item_o <= c`, `v_o <= 1`, go to HOLD.
    - In mode 1, `used <= ((used | 1<<c) == all-ones) ? 0 : (used | 1<<c)`. The bag refills on the last item.
    - Mode 0 never modifies `used`.
- State HOLD:
  - `v_o = 1`. `item_o` stays stable until the handshake.
  - Handshake: `v_o <= 0`, go to DRAW.
- Priority: `reset_i` > `seed_v_i` > handshake/draw.
  - `seed_v_i` in any state reloads the LFSR, clears `used`, deasserts `v_o` next cycle, and goes to DRAW. A pending un-accepted item is discarded.
- Mode switch mid-bag does not clear `used`. A return to mode 1 resumes the partial bag.
- `items_p` equal to a power of two means no rejection in mode 0.

## Timing
- Reset values:
  - State IDLE, `v_o = 0`, `item_o = 0`, `used = 0`, `lfsr = 1`.
- Seed in cycle N: DRAW evaluates `lfsr = seed` in N+1.
  - If accepted, `v_o = 1` in N+2.
  - Each rejection adds one cycle.
- Handshake in cycle H: `v_o = 0` in H+1 (DRAW), and the earliest next `v_o = 1` is H+2.
  - Maximum throughput is one item per 2 cycles.
- Draw latency is bounded by the LFSR period, since the period covers every candidate value.
- Outputs are registered. There is no combinational path from `ready_i` or `mode_i` to `v_o` or `item_o`.
- Reset asserted in any state: IDLE with reset values on the next edge. Nothing is emitted until `seed_v_i`.

## Test plan
- **Basic sequence.** Config `width_p = 4`, `mask_p = 4'b1100`, `items_p = 7`, `mode_i = 0`, `ready_i = 1`. Pulse `seed_v_i` with `seed_i = 4'b0001` at cycle 0.
  - Required: `v_o = 1` with `item_o = 1` at cycle 2, `v_o = 0` at cycle 3, and `item_o = 6` at cycle 4 (LFSR 0001 → 1100 → 0110).
- **Zero seed.** Same config, `seed_i = 0`.
  - Required: output identical to `seed_i = 1`. First item is 1 at cycle 2.
- **Bag mode.** Default parameters, `mode_i = 1`, `ready_i = 1`, draw 21 items.
  - Required: each consecutive group of 7 is a permutation of {0..6}, and the value 7 never appears.
- **Uniform mode.** Default parameters, `mode_i = 0`, 2000 draws.
  - Required: all items < 7, every value 0..6 appears at least once, and repeats within 7 consecutive draws are observed.
- **Backpressure.** Hold `ready_i = 0` for 5 cycles while `v_o = 1`.
  - Required: `v_o` stays 1 and `item_o` is unchanged for all 5 cycles. Assert `ready_i`, and `v_o = 0` on the next cycle.
- **Mid-operation reset and re-seed.** Assert `reset_i` in HOLD.
  - Required: `v_o = 0` on the next cycle and no output until seeded.
  - Then pulse `seed_v_i` in HOLD in bag mode after 3 items. Required: `v_o = 0` the next cycle, and the following 7 items form a complete permutation.

Source files
------------

// File: rtl/random_bag_generator.sv
// Galois-LFSR rejection sampler emitting item indices in [0, items_p) over valid/ready,
// either uniformly with replacement or as bags where every items_p draws form a permutation.
module random_bag_generator #(
    parameter int                 width_p = 16,
    parameter logic [width_p-1:0] mask_p  = 16'hB400,
    parameter int                 items_p = 7,
    localparam int                iw      = $clog2(items_p)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] seed_i,
    input  logic               seed_v_i,
    input  logic               mode_i,
    output logic               v_o,
    output logic [iw-1:0]      item_o,
    input  logic               ready_i
);

    typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

    localparam logic [iw:0]        items_c = (iw+1)'(items_p);
    localparam logic [items_p-1:0] one_c   = items_p'(1);

    state_t             state_q, state_d;
    logic [width_p-1:0] lfsr_q, lfsr_d;
    logic [items_p-1:0] used_q, used_d;
    logic [iw-1:0]      item_q, item_d;
    logic               v_q, v_d;

    logic [width_p-1:0] lfsr_step;
    logic [iw-1:0]      cand;
    logic [items_p-1:0] cand_bit;
    logic [items_p-1:0] used_next;
    logic               cand_ok;
    logic               used_ok;
    logic               accept;
    logic               handshake;

    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? mask_p : '0);
    assign cand      = lfsr_q[iw-1:0];
    // Out-of-range candidates shift the one-hot bit off the top, so they never touch used.
    assign cand_bit  = one_c << cand;
    assign used_next = used_q | cand_bit;
    assign cand_ok   = ({1'b0, cand} < items_c);
    assign used_ok   = !mode_i || ((used_q & cand_bit) == '0);
    assign accept    = (state_q == DRAW) && cand_ok && used_ok;
    assign handshake = (state_q == HOLD) && ready_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            lfsr_q  <= width_p'(1);
            used_q  <= '0;
            item_q  <= '0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            used_q  <= used_d;
            item_q  <= item_d;
            v_q     <= v_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DRAW:    if (accept)    state_d = HOLD;
            HOLD:    if (handshake) state_d = DRAW;
            default: state_d = state_q;
        endcase
        if (seed_v_i) state_d = DRAW;
    end

    always_comb begin
        lfsr_d = lfsr_q;
        used_d = used_q;
        item_d = item_q;
        v_d    = v_q;
        if (state_q != IDLE) lfsr_d = lfsr_step;
        if (accept) begin
            item_d = cand;
            v_d    = 1'b1;
            // The bag refills as soon as its last item is drawn.
            if (mode_i) used_d = (used_next == '1) ? '0 : used_next;
        end
        if (handshake) v_d = 1'b0;
        if (seed_v_i) begin
            lfsr_d = (seed_i == '0) ? width_p'(1) : seed_i;
            used_d = '0;
            v_d    = 1'b0;
        end
    end

    assign v_o    = v_q;
    assign item_o = item_q;

endmodule

// File: tb/tb_random_bag_generator.sv
// Directed bench: a 4-bit LFSR instance checked cycle by cycle from a vector table,
// and the default 16-bit instance checked with bag / uniform / backpressure / reset sequences.
module tb_random_bag_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        seed_v;
    logic        mode;
    logic        ready;
    logic [3:0]  seed_s;
    logic [15:0] seed_b;
    logic        v_s, v_b;
    logic [2:0]  item_s, item_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    random_bag_generator #(.width_p(4), .mask_p(4'b1100), .items_p(7)) u_small (
        .clk_i(clk), .reset_i(reset), .seed_i(seed_s), .seed_v_i(seed_v), .mode_i(mode),
        .v_o(v_s), .item_o(item_s), .ready_i(ready)
    );

    random_bag_generator u_dut (
        .clk_i(clk), .reset_i(reset), .seed_i(seed_b), .seed_v_i(seed_v), .mode_i(mode),
        .v_o(v_b), .item_o(item_b), .ready_i(ready)
    );

    typedef struct {
        logic       seed_v;
        logic [3:0] seed;
        logic       ready;
        logic       exp_v;
        logic       chk_item;
        logic [2:0] exp_item;
    } vec_t;

    vec_t vecs[22];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic get_item(output logic [2:0] it, output bit ok);
        ok = 1'b0;
        it = '0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (v_b) begin
                it = item_b;
                ok = 1'b1;
                break;
            end
        end
        check("draw_timeout", 32'(ok), 32'd1);
    endtask

    task automatic pulse_seed(input logic [15:0] s);
        seed_b = s;
        seed_v = 1'b1;
        step();
        seed_v = 1'b0;
    endtask

    task automatic check_bag(input string name);
        logic [6:0] seen;
        logic [2:0] it;
        bit         ok;
        seen = '0;
        for (int i = 0; i < 7; i++) begin
            get_item(it, ok);
            check({name, "_range"}, 32'(it < 3'd7), 32'd1);
            if (it < 3'd7) seen[it] = 1'b1;
        end
        check({name, "_perm"}, 32'(seen), 32'h7f);
    endtask

    initial begin
        logic [2:0] it, held;
        bit         ok;
        int         cnt[7];
        int         bad, rep;
        logic [2:0] hist[$];

        // Small instance, mode 0: LFSR 1,C,6,3,D,A,5,E,7,F,B -> low bits 1,4,6,3,5,2,5,6,7,7,3
        vecs[0]  = '{1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 3'd0};
        vecs[1]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 3'd1};
        vecs[2]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd1};
        vecs[3]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 3'd6};
        vecs[4]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd6};
        vecs[5]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 3'd5};
        vecs[6]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd5};
        vecs[7]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 3'd5};
        vecs[8]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd5};
        vecs[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd5};
        vecs[10] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd5};
        vecs[11] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 3'd3};
        vecs[12] = '{1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[13] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 3'd1};
        vecs[14] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd1};
        vecs[15] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 3'd6};
        vecs[16] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 3'd6};
        vecs[17] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 3'd6};
        vecs[18] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 3'd6};
        vecs[19] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 3'd6};
        vecs[20] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 3'd6};
        vecs[21] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd6};

        reset  = 1'b1;
        seed_v = 1'b0;
        seed_s = '0;
        seed_b = '0;
        mode   = 1'b0;
        ready  = 1'b1;
        step();
        step();
        check("rst_v_small", 32'(v_s), 32'd0);
        check("rst_item_small", 32'(item_s), 32'd0);
        check("rst_v", 32'(v_b), 32'd0);
        check("rst_item", 32'(item_b), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_no_output", 32'(v_s | v_b), 32'd0);
        end

        for (int i = 0; i < 22; i++) begin
            seed_v = vecs[i].seed_v;
            seed_s = vecs[i].seed;
            ready  = vecs[i].ready;
            step();
            check($sformatf("vec%0d_v", i), 32'(v_s), 32'(vecs[i].exp_v));
            if (vecs[i].chk_item)
                check($sformatf("vec%0d_item", i), 32'(item_s), 32'(vecs[i].exp_item));
        end
        seed_v = 1'b0;

        // Bag mode: three full bags.
        mode  = 1'b1;
        ready = 1'b1;
        pulse_seed(16'hACE1);
        for (int g = 0; g < 3; g++) check_bag("bag");

        // Uniform mode.
        mode = 1'b0;
        pulse_seed(16'h1234);
        bad = 0;
        rep = 0;
        for (int v = 0; v < 7; v++) cnt[v] = 0;
        for (int n = 0; n < 2000; n++) begin
            get_item(it, ok);
            if (!ok) break;
            if (it >= 3'd7) bad++;
            else cnt[it]++;
            foreach (hist[j]) if (hist[j] == it) rep = 1;
            hist.push_back(it);
            if (hist.size() > 6) void'(hist.pop_front());
        end
        check("uni_range", 32'(bad), 32'd0);
        for (int v = 0; v < 7; v++) check($sformatf("uni_seen%0d", v), 32'(cnt[v] > 0), 32'd1);
        check("uni_repeat", 32'(rep), 32'd1);

        // Backpressure on the default instance.
        ready = 1'b0;
        pulse_seed(16'hBEEF);
        get_item(held, ok);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_v", 32'(v_b), 32'd1);
            check("bp_item", 32'(item_b), 32'(held));
        end
        ready = 1'b1;
        step();
        check("bp_release_v", 32'(v_b), 32'd0);

        // Reset while holding an item.
        ready = 1'b0;
        get_item(it, ok);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_v", 32'(v_b), 32'd0);
        check("midrst_item", 32'(item_b), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("midrst_idle", 32'(v_b), 32'd0);
        end

        // Re-seed in HOLD after three bag items; the next seven form a fresh bag.
        mode  = 1'b1;
        ready = 1'b1;
        pulse_seed(16'h0F0F);
        for (int i = 0; i < 3; i++) get_item(it, ok);
        ready = 1'b0;
        get_item(it, ok);
        pulse_seed(16'h5A5A);
        check("reseed_v", 32'(v_b), 32'd0);
        ready = 1'b1;
        check_bag("reseed_bag");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
